// File: rtl/md_pad_pkg.sv
// Shared types and default timing for the memory-data pad sequencer.
package md_pad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        TURN   = 3'd2,
        RDWAIT = 3'd3,
        RESP   = 3'd4
    } md_seq_state_e;

    localparam int MD_W      = 8;
    localparam int MD_WR_CYC = 2;
    localparam int MD_TA_CYC = 1;
    localparam int MD_RD_DLY = 2;

    // Enough bits for the largest phase length, plus headroom.
    function automatic int md_cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/md_pad_cnt.sv
// Loadable down-counter with zero flag; holds at zero.
module md_pad_cnt #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/md_pad_seq.sv
// Request sequencer for the memory-data pad: timed write drive,
// bus turnaround and delayed read sampling with a response handshake.
module md_pad_seq
    import md_pad_pkg::*;
#(
    parameter int W      = MD_W,
    parameter int WR_CYC = MD_WR_CYC,
    parameter int TA_CYC = MD_TA_CYC,
    parameter int RD_DLY = MD_RD_DLY
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [W-1:0]   req_wdata,
    output logic [W-1:0]   pin_out,
    output logic           pin_outen,
    input  logic [2*W-1:0] pin_in,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_rdata,
    output logic           busy
);

    localparam int CW = md_cnt_w(WR_CYC, TA_CYC, RD_DLY);
    localparam logic [CW-1:0] LD_WR = CW'(WR_CYC - 1);
    localparam logic [CW-1:0] LD_TA = CW'(TA_CYC - 1);
    localparam logic [CW-1:0] LD_RD = CW'(RD_DLY - 1);

    md_seq_state_e r_state;
    md_seq_state_e w_nxt;

    logic           r_outen;
    logic [W-1:0]   r_out;
    logic           r_rv;
    logic [2*W-1:0] r_rdata;
    logic           r_ready;

    logic           w_outen_nxt;
    logic [W-1:0]   w_out_nxt;
    logic           w_rv_nxt;
    logic [2*W-1:0] w_rd_nxt;
    logic           w_ready_nxt;
    logic           w_ld;
    logic [CW-1:0]  w_ldv;
    logic           w_dec;
    logic           w_zero;
    logic           w_acc;

    assign w_acc = req_valid && r_ready;

    md_pad_cnt #(.CW(CW)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_ld),
        .i_val  (w_ldv),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt       = r_state;
        w_ld        = 1'b0;
        w_ldv       = '0;
        w_dec       = 1'b0;
        w_outen_nxt = 1'b0;
        w_out_nxt   = r_out;
        w_rv_nxt    = r_rv;
        w_rd_nxt    = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_acc && req_write) begin
                    w_nxt       = DRIVE;
                    w_ld        = 1'b1;
                    w_ldv       = LD_WR;
                    w_outen_nxt = 1'b1;
                    w_out_nxt   = req_wdata;
                end else if (w_acc) begin
                    w_nxt = RDWAIT;
                    w_ld  = 1'b1;
                    w_ldv = LD_RD;
                end
            end
            DRIVE: begin
                if (w_zero) begin
                    w_nxt = TURN;
                    w_ld  = 1'b1;
                    w_ldv = LD_TA;
                end else begin
                    w_outen_nxt = 1'b1;
                    w_dec       = 1'b1;
                end
            end
            TURN: begin
                if (w_zero) w_nxt = IDLE;
                else        w_dec = 1'b1;
            end
            RDWAIT: begin
                if (w_zero) begin
                    w_nxt    = RESP;
                    w_rv_nxt = 1'b1;
                    w_rd_nxt = pin_in;
                end else begin
                    w_dec = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_nxt    = IDLE;
                    w_rv_nxt = 1'b0;
                end
            end
            default: begin
                w_nxt     = IDLE;
                w_out_nxt = '0;
                w_rv_nxt  = 1'b0;
                w_rd_nxt  = '0;
            end
        endcase
        // Registered so it reads 0 while reset is held.
        w_ready_nxt = (w_nxt == IDLE) && !w_rv_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outen <= 1'b0;
            r_out   <= '0;
            r_rv    <= 1'b0;
            r_rdata <= '0;
            r_ready <= 1'b0;
        end else begin
            r_outen <= w_outen_nxt;
            r_out   <= w_out_nxt;
            r_rv    <= w_rv_nxt;
            r_rdata <= w_rd_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign pin_outen = r_outen;
    assign pin_out   = r_out;
    assign rsp_valid = r_rv;
    assign rsp_rdata = r_rdata;
    assign req_ready = r_ready;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_md_pad_seq.sv
// Self-checking bench for md_pad_seq: vector table, random transactions,
// and hand-written turnaround and reset sequences.
module tb_md_pad_seq;

    localparam int W  = 8;
    localparam int WR = 2;
    localparam int TA = 1;
    localparam int RD = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_write = 1'b0;
    logic [W-1:0]   req_wdata = '0;
    logic [W-1:0]   pin_out;
    logic           pin_outen;
    logic [2*W-1:0] pin_in = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [2*W-1:0] rsp_rdata;
    logic           busy;

    int n_run  = 0;
    int n_fail = 0;

    md_pad_seq #(
        .W(W), .WR_CYC(WR), .TA_CYC(TA), .RD_DLY(RD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .pin_out   (pin_out),
        .pin_outen (pin_outen),
        .pin_in    (pin_in),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk1("ready_timeout", req_ready, 1'b1);
    endtask

    task automatic idle_chk();
        chk1("idle_ready", req_ready, 1'b1);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_outen", pin_outen, 1'b0);
        chk1("idle_rv", rsp_valid, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] d, input logic [15:0] exp);
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 8'($urandom);
        for (int i = 0; i < WR; i++) begin
            if (i > 0) @(negedge clk);
            chk1("wr_outen", pin_outen, 1'b1);
            chkv("wr_pin_out", 16'(pin_out), exp);
            chk1("wr_ready", req_ready, 1'b0);
        end
        for (int i = 0; i < TA; i++) begin
            @(negedge clk);
            chk1("ta_outen", pin_outen, 1'b0);
            chkv("ta_pin_out", 16'(pin_out), exp);
            chk1("ta_ready", req_ready, 1'b0);
        end
        @(negedge clk);
        chk1("wr_done_ready", req_ready, 1'b1);
        chk1("wr_done_busy", busy, 1'b0);
    endtask

    task automatic do_read(input logic [15:0] cap, input int stall,
                           input logic [15:0] exp);
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        pin_in    = 16'($urandom);
        for (int i = 1; i <= RD; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk1("rd_outen", pin_outen, 1'b0);
            chk1("rd_rv_early", rsp_valid, 1'b0);
            chk1("rd_busy", busy, 1'b1);
            pin_in = (i == RD) ? cap : 16'($urandom);
        end
        @(negedge clk);
        chk1("rsp_valid", rsp_valid, 1'b1);
        chkv("rsp_rdata", rsp_rdata, exp);
        chk1("rsp_outen", pin_outen, 1'b0);
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            pin_in    = 16'($urandom);
            @(negedge clk);
            chk1("stall_rv", rsp_valid, 1'b1);
            chkv("stall_rdata", rsp_rdata, exp);
            chk1("stall_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("hs_rv", rsp_valid, 1'b0);
        chk1("hs_ready", req_ready, 1'b1);
        chk1("hs_busy", busy, 1'b0);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  wd;
        logic [15:0] pin;
        int          stall;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 16'h0000, 0, 16'h00A5};
        tbl[1] = '{1'b0, 8'h00, 16'h3C5A, 0, 16'h3C5A};
        tbl[2] = '{1'b0, 8'h00, 16'hBEEF, 5, 16'hBEEF};
        tbl[3] = '{1'b1, 8'h00, 16'h0000, 0, 16'h0000};
        tbl[4] = '{1'b1, 8'hFF, 16'h0000, 0, 16'h00FF};
        tbl[5] = '{1'b0, 8'h00, 16'h0000, 1, 16'h0000};
        tbl[6] = '{1'b0, 8'h00, 16'hFFFF, 2, 16'hFFFF};

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk1("rst_ready", req_ready, 1'b0);
        chk1("rst_outen", pin_outen, 1'b0);
        chkv("rst_pin_out", 16'(pin_out), 16'h0000);
        chk1("rst_rv", rsp_valid, 1'b0);
        chkv("rst_rdata", rsp_rdata, 16'h0000);
        chk1("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk();

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].wr) do_write(tbl[i].wd, tbl[i].exp);
            else           do_read(tbl[i].pin, tbl[i].stall, tbl[i].exp);
        end

        // Write then read with req_valid held high throughout
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 8'h5A;
        pin_in    = 16'h1234;
        @(negedge clk);
        req_write = 1'b0;
        for (int i = 0; i < WR; i++) begin
            if (i > 0) @(negedge clk);
            chk1("b2b_wr_outen", pin_outen, 1'b1);
        end
        for (int i = 0; i < TA; i++) begin
            @(negedge clk);
            chk1("b2b_ta_outen", pin_outen, 1'b0);
            chk1("b2b_ta_ready", req_ready, 1'b0);
        end
        @(negedge clk);
        chk1("b2b_rd_accept", req_ready, 1'b1);
        chk1("b2b_acc_outen", pin_outen, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        chk1("b2b_rd_busy", busy, 1'b1);
        chk1("b2b_rd_ready", req_ready, 1'b0);
        chk1("b2b_rd_outen", pin_outen, 1'b0);
        for (int i = 2; i <= RD; i++) begin
            @(negedge clk);
            chk1("b2b_rd_outen", pin_outen, 1'b0);
            chk1("b2b_rd_rv", rsp_valid, 1'b0);
        end
        @(negedge clk);
        chk1("b2b_rsp_valid", rsp_valid, 1'b1);
        chkv("b2b_rsp_rdata", rsp_rdata, 16'h1234);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        idle_chk();

        // Random transactions
        for (int n = 0; n < 50; n++) begin
            logic [15:0] cap;
            logic [7:0]  d;
            int          gap;
            cap = 16'($urandom);
            d   = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(d, {8'h00, d});
            else do_read(cap, int'($urandom_range(0, 4)), cap);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                idle_chk();
            end
        end

        // Reset pulse during the first drive cycle
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 8'hC3;
        @(negedge clk);
        req_valid = 1'b0;
        chk1("mid_drive_outen", pin_outen, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("async_outen", pin_outen, 1'b0);
        chk1("async_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk();

        // Reset while a response is pending discards it
        req_valid = 1'b1;
        req_write = 1'b0;
        pin_in    = 16'h7E81;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (RD) @(negedge clk);
        chk1("pend_rv", rsp_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("pend_rv_drop", rsp_valid, 1'b0);
        chkv("pend_rdata_clr", rsp_rdata, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_chk();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
